// File: rtl/issueque_int_pkg.sv
// Shared constants for the integer issue queue: default geometry and the
// ALU opcode/funct encodings also used by issueint.
package issueque_int_pkg;

    localparam int OP_W          = 6;
    localparam int ISSUEQ_DEPTH  = 4;
    localparam int ISSUEQ_TAG_W  = 6;
    localparam int ISSUEQ_DATA_W = 32;

    localparam logic [OP_W-1:0] OP_ADD = 6'h20;
    localparam logic [OP_W-1:0] OP_SUB = 6'h22;
    localparam logic [OP_W-1:0] OP_AND = 6'h24;
    localparam logic [OP_W-1:0] OP_OR  = 6'h25;

endpackage

// File: rtl/issueque_int_if.sv
// Dispatch, CDB snoop and issue-side signals of the integer issue queue.
// master = dispatcher/CDB/arbiter side, slave = the queue itself.
interface issueque_int_if
    import issueque_int_pkg::*;
#(
    parameter int TAG_W  = ISSUEQ_TAG_W,
    parameter int DATA_W = ISSUEQ_DATA_W
);
    logic              dispatch_valid;
    logic [OP_W-1:0]   dispatch_opcode;
    logic [DATA_W-1:0] dispatch_rsdata;
    logic              dispatch_rsvalid;
    logic [TAG_W-1:0]  dispatch_rstag;
    logic [DATA_W-1:0] dispatch_rtdata;
    logic              dispatch_rtvalid;
    logic [TAG_W-1:0]  dispatch_rttag;
    logic [TAG_W-1:0]  dispatch_rdtag;
    logic              issueque_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issueint_grant;
    logic              issueint_ready;
    logic [OP_W-1:0]   issueint_opcode;
    logic [DATA_W-1:0] issueint_rsdata;
    logic [DATA_W-1:0] issueint_rtdata;
    logic [TAG_W-1:0]  issueint_rdtag;

    modport master (
        output dispatch_valid, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
               dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
               dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issueint_grant,
        input  issueque_full, issueint_ready, issueint_opcode, issueint_rsdata,
               issueint_rtdata, issueint_rdtag
    );

    modport slave (
        input  dispatch_valid, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
               dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
               dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issueint_grant,
        output issueque_full, issueint_ready, issueint_opcode, issueint_rsdata,
               issueint_rtdata, issueint_rdtag
    );
endinterface

// File: rtl/issueque_select.sv
// Lowest-index priority encoder: one-hot grant, binary index and found flag.
module issueque_select #(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             found
);
    // seen[i] is set when any entry below i is eligible
    logic [DEPTH:0] seen;

    assign seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chain
            assign grant[gi]  = eligible[gi] & ~seen[gi];
            assign seen[gi+1] = seen[gi] | eligible[gi];
        end
    endgenerate

    assign found = seen[DEPTH];

    always_comb begin
        index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) index = IDX_W'(i);
        end
    end
endmodule

// File: rtl/issueque_int.sv
// Collapsing integer issue queue: CDB wakeup, oldest-ready select, and a
// registered issue port feeding issueint directly.
module issueque_int
    import issueque_int_pkg::*;
#(
    parameter int DEPTH  = ISSUEQ_DEPTH,
    parameter int TAG_W  = ISSUEQ_TAG_W,
    parameter int DATA_W = ISSUEQ_DATA_W
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    issueque_int_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] rsdata;
        logic              rsvalid;
        logic [TAG_W-1:0]  rstag;
        logic [DATA_W-1:0] rtdata;
        logic              rtvalid;
        logic [TAG_W-1:0]  rttag;
        logic [TAG_W-1:0]  rdtag;
    } entry_t;

    // Tags are only looked at while the operand is still pending.
    function automatic entry_t wake_entry(input entry_t e, input logic cv,
                                          input logic [TAG_W-1:0] ct,
                                          input logic [DATA_W-1:0] cd);
        entry_t r = e;
        if (cv && e.valid && !e.rsvalid && (e.rstag == ct)) begin
            r.rsvalid = 1'b1;
            r.rsdata  = cd;
        end
        if (cv && e.valid && !e.rtvalid && (e.rttag == ct)) begin
            r.rtvalid = 1'b1;
            r.rtdata  = cd;
        end
        return r;
    endfunction

    entry_t            q_reg  [DEPTH];
    entry_t            q_next [DEPTH];
    entry_t            woken  [DEPTH];
    entry_t            disp_entry;
    entry_t            winner;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DEPTH-1:0]  eligible, sel_grant;
    logic [IDX_W-1:0]  sel_idx, wr_idx;
    logic              sel_found, do_issue, accept, full;
    logic              ready_reg;
    logic [OP_W-1:0]   opcode_reg;
    logic [DATA_W-1:0] rsdata_reg, rtdata_reg;
    logic [TAG_W-1:0]  rdtag_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign eligible[gi] = q_reg[gi].valid & q_reg[gi].rsvalid & q_reg[gi].rtvalid;
            assign woken[gi]    = wake_entry(q_reg[gi], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
    endgenerate

    issueque_select #(.DEPTH(DEPTH)) u_select (
        .eligible (eligible),
        .grant    (sel_grant),
        .index    (sel_idx),
        .found    (sel_found)
    );

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign do_issue = sel_found & bus.issueint_grant;
    assign accept   = bus.dispatch_valid & ~full;
    assign wr_idx   = IDX_W'(count_reg - CNT_W'(do_issue));

    always_comb begin
        entry_t d;
        d         = '0;
        d.valid   = 1'b1;
        d.opcode  = bus.dispatch_opcode;
        d.rsdata  = bus.dispatch_rsdata;
        d.rsvalid = bus.dispatch_rsvalid;
        d.rstag   = bus.dispatch_rstag;
        d.rtdata  = bus.dispatch_rtdata;
        d.rtvalid = bus.dispatch_rtvalid;
        d.rttag   = bus.dispatch_rttag;
        d.rdtag   = bus.dispatch_rdtag;
        disp_entry = wake_entry(d, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    always_comb begin
        winner = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_grant[i]) winner = winner | q_reg[i];
        end
    end

    // Collapse above the issued slot, then append the dispatched op at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) q_next[i] = woken[i];
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) q_next[i] = woken[i+1];
            end
            q_next[DEPTH-1] = '0;
        end
        if (accept) q_next[wr_idx] = disp_entry;
        count_next = count_reg - CNT_W'(do_issue) + CNT_W'(accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
            opcode_reg <= '0;
            rsdata_reg <= '0;
            rtdata_reg <= '0;
            rdtag_reg  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
            count_reg <= '0;
            ready_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q_reg[i] <= q_next[i];
            count_reg <= count_next;
            ready_reg <= do_issue;
            if (do_issue) begin
                opcode_reg <= winner.opcode;
                rsdata_reg <= winner.rsdata;
                rtdata_reg <= winner.rtdata;
                rdtag_reg  <= winner.rdtag;
            end
        end
    end

    assign bus.issueque_full   = full;
    assign bus.issueint_ready  = ready_reg;
    assign bus.issueint_opcode = opcode_reg;
    assign bus.issueint_rsdata = rsdata_reg;
    assign bus.issueint_rtdata = rtdata_reg;
    assign bus.issueint_rdtag  = rdtag_reg;
endmodule

// File: tb/tb_issueque_int.sv
// Directed bench for issueque_int: latency, wakeup, full/drop, grant stall,
// dispatch bypass, flush and mid-run reset.
module tb_issueque_int;
    import issueque_int_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    issueque_int_if #(.TAG_W(6), .DATA_W(32)) bus ();

    issueque_int #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] rsd, input logic rsv,
                            input logic [5:0] rst, input logic [31:0] rtd, input logic rtv,
                            input logic [5:0] rtt, input logic [5:0] rdt);
        bus.dispatch_valid   = 1'b1;
        bus.dispatch_opcode  = op;
        bus.dispatch_rsdata  = rsd;
        bus.dispatch_rsvalid = rsv;
        bus.dispatch_rstag   = rst;
        bus.dispatch_rtdata  = rtd;
        bus.dispatch_rtvalid = rtv;
        bus.dispatch_rttag   = rtt;
        bus.dispatch_rdtag   = rdt;
    endtask

    task automatic no_dispatch();
        bus.dispatch_valid = 1'b0;
    endtask

    task automatic cdb(input logic v, input logic [5:0] tag, input logic [31:0] data);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    task automatic test_reset();
        logic [5:0] zero_tag;
        zero_tag = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (bus.issueint_ready !== 1'b0 || bus.issueque_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags ready=%b full=%b want 0 0", bus.issueint_ready, bus.issueque_full);
        end
        checks++;
        if (bus.issueint_rsdata !== 32'h0 || bus.issueint_rtdata !== 32'h0 ||
            bus.issueint_rdtag !== zero_tag || bus.issueint_opcode !== 6'h0) begin
            failures++;
            $display("FAIL reset_data rs=%h rt=%h rd=%h op=%h want zeros", bus.issueint_rsdata,
                     bus.issueint_rtdata, bus.issueint_rdtag, bus.issueint_opcode);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_latency();
        bus.issueint_grant = 1'b1;
        dispatch(OP_ADD, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd3);
        tick();
        no_dispatch();
        checks++;
        if (bus.issueint_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_early ready=%b want 0", bus.issueint_ready);
        end
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b1 || bus.issueint_rsdata !== 32'd5 || bus.issueint_rtdata !== 32'd7 ||
            bus.issueint_rdtag !== 6'd3 || bus.issueint_opcode !== OP_ADD) begin
            failures++;
            $display("FAIL basic_issue ready=%b rs=%0d rt=%0d rd=%0d op=%h want 1 5 7 3 %h",
                     bus.issueint_ready, bus.issueint_rsdata, bus.issueint_rtdata,
                     bus.issueint_rdtag, bus.issueint_opcode, OP_ADD);
        end
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse ready=%b want 0", bus.issueint_ready);
        end
        $display("test_basic_latency done");
    endtask

    task automatic test_wakeup();
        dispatch(OP_SUB, 32'd0, 1'b0, 6'd9, 32'd2, 1'b1, 6'd0, 6'd4);
        tick();
        no_dispatch();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.issueint_ready !== 1'b0) begin
                failures++;
                $display("FAIL wake_premature cycle=%0d ready=%b want 0", i, bus.issueint_ready);
            end
        end
        cdb(1'b1, 6'd9, 32'd20);
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        checks++;
        if (bus.issueint_ready !== 1'b0) begin
            failures++;
            $display("FAIL wake_same_cycle ready=%b want 0", bus.issueint_ready);
        end
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b1 || bus.issueint_rsdata !== 32'd20 || bus.issueint_rtdata !== 32'd2 ||
            bus.issueint_rdtag !== 6'd4 || bus.issueint_opcode !== OP_SUB) begin
            failures++;
            $display("FAIL wake_issue ready=%b rs=%0d rt=%0d rd=%0d want 1 20 2 4",
                     bus.issueint_ready, bus.issueint_rsdata, bus.issueint_rtdata, bus.issueint_rdtag);
        end
        tick();
        $display("test_wakeup done");
    endtask

    task automatic test_full();
        logic [5:0] want [3];
        want[0] = 6'd40; want[1] = 6'd41; want[2] = 6'd43;
        bus.issueint_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dispatch(OP_OR, 32'd0, 1'b0, 6'(20 + i), 32'd1, 1'b1, 6'd0, 6'(40 + i));
            tick();
            if (i == 2) begin
                checks++;
                if (bus.issueque_full !== 1'b0) begin
                    failures++;
                    $display("FAIL full_early full=%b want 0", bus.issueque_full);
                end
            end
        end
        checks++;
        if (bus.issueque_full !== 1'b1) begin
            failures++;
            $display("FAIL full_set full=%b want 1", bus.issueque_full);
        end
        // A ready op offered while full must be dropped and never issue.
        dispatch(OP_ADD, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd44);
        tick();
        no_dispatch();
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b0 || bus.issueque_full !== 1'b1) begin
            failures++;
            $display("FAIL full_drop ready=%b full=%b want 0 1", bus.issueint_ready, bus.issueque_full);
        end
        cdb(1'b1, 6'd22, 32'h22);
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd42 || bus.issueint_rsdata !== 32'h22 ||
            bus.issueque_full !== 1'b0) begin
            failures++;
            $display("FAIL full_mid_issue ready=%b rd=%0d rs=%h full=%b want 1 42 22 0",
                     bus.issueint_ready, bus.issueint_rdtag, bus.issueint_rsdata, bus.issueque_full);
        end
        bus.issueint_grant = 1'b0;
        cdb(1'b1, 6'd23, 32'h23); tick();
        cdb(1'b1, 6'd21, 32'h21); tick();
        cdb(1'b1, 6'd20, 32'h20); tick();
        cdb(1'b0, 6'd0, 32'd0);
        bus.issueint_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== want[i]) begin
                failures++;
                $display("FAIL full_order slot=%0d ready=%b rd=%0d want 1 %0d",
                         i, bus.issueint_ready, bus.issueint_rdtag, want[i]);
            end
        end
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_drained ready=%b want 0", bus.issueint_ready);
        end
        $display("test_full done");
    endtask

    task automatic test_grant_stall();
        bus.issueint_grant = 1'b0;
        dispatch(OP_AND, 32'd10, 1'b1, 6'd0, 32'd11, 1'b1, 6'd0, 6'd50); tick();
        dispatch(OP_AND, 32'd12, 1'b1, 6'd0, 32'd13, 1'b1, 6'd0, 6'd51); tick();
        no_dispatch();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.issueint_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_issue cycle=%0d ready=%b want 0", i, bus.issueint_ready);
            end
        end
        bus.issueint_grant = 1'b1;
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd50 || bus.issueint_rsdata !== 32'd10) begin
            failures++;
            $display("FAIL stall_first ready=%b rd=%0d rs=%0d want 1 50 10",
                     bus.issueint_ready, bus.issueint_rdtag, bus.issueint_rsdata);
        end
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd51 || bus.issueint_rtdata !== 32'd13) begin
            failures++;
            $display("FAIL stall_second ready=%b rd=%0d rt=%0d want 1 51 13",
                     bus.issueint_ready, bus.issueint_rdtag, bus.issueint_rtdata);
        end
        tick();
        $display("test_grant_stall done");
    endtask

    task automatic test_dispatch_bypass();
        bus.issueint_grant = 1'b1;
        dispatch(OP_ADD, 32'd0, 1'b0, 6'd12, 32'd1, 1'b1, 6'd0, 6'd14);
        cdb(1'b1, 6'd12, 32'hABCD);
        tick();
        no_dispatch();
        cdb(1'b0, 6'd0, 32'd0);
        tick();
        checks++;
        if (bus.issueint_ready !== 1'b1 || bus.issueint_rsdata !== 32'hABCD || bus.issueint_rdtag !== 6'd14) begin
            failures++;
            $display("FAIL bypass_issue ready=%b rs=%h rd=%0d want 1 abcd 14",
                     bus.issueint_ready, bus.issueint_rsdata, bus.issueint_rdtag);
        end
        tick();
        $display("test_dispatch_bypass done");
    endtask

    task automatic test_flush();
        bus.issueint_grant = 1'b0;
        dispatch(OP_ADD, 32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd60); tick();
        dispatch(OP_ADD, 32'd0, 1'b0, 6'd31, 32'd2, 1'b1, 6'd0, 6'd61); tick();
        dispatch(OP_ADD, 32'd0, 1'b0, 6'd32, 32'd2, 1'b1, 6'd0, 6'd62); tick();
        bus.issueint_grant = 1'b1;
        flush = 1'b1;
        dispatch(OP_ADD, 32'd3, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 6'd63);
        tick();
        flush = 1'b0;
        no_dispatch();
        checks++;
        if (bus.issueint_ready !== 1'b0 || bus.issueque_full !== 1'b0) begin
            failures++;
            $display("FAIL flush_state ready=%b full=%b want 0 0", bus.issueint_ready, bus.issueque_full);
        end
        cdb(1'b1, 6'd31, 32'h31); tick();
        cdb(1'b1, 6'd32, 32'h32); tick();
        cdb(1'b0, 6'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.issueint_ready !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost cycle=%0d ready=%b rd=%0d want 0",
                         i, bus.issueint_ready, bus.issueint_rdtag);
            end
        end
        // Count must restart from zero: only the fourth new entry fills the queue.
        for (int i = 0; i < 4; i++) begin
            dispatch(OP_SUB, 32'd0, 1'b0, 6'(33 + i), 32'd0, 1'b1, 6'd0, 6'(20 + i));
            tick();
            checks++;
            if (bus.issueque_full !== (i == 3)) begin
                failures++;
                $display("FAIL flush_count n=%0d full=%b want %b", i + 1, bus.issueque_full, (i == 3));
            end
        end
        no_dispatch();
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.issueque_full !== 1'b0 || bus.issueint_ready !== 1'b0 || bus.issueint_rsdata !== 32'h0 ||
            bus.issueint_rdtag !== 6'd0) begin
            failures++;
            $display("FAIL reset_mid full=%b ready=%b rs=%h rd=%0d want 0 0 0 0",
                     bus.issueque_full, bus.issueint_ready, bus.issueint_rsdata, bus.issueint_rdtag);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.issueint_grant = 1'b0;
        dispatch(OP_ADD, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
        no_dispatch();
        cdb(1'b0, 6'd0, 32'd0);
        test_reset();
        test_basic_latency();
        test_wakeup();
        test_full();
        test_grant_stall();
        test_dispatch_bypass();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issueque_int.md
Name: issueque_int

Overview:
- Integer issue queue and scheduler in front of the integer ALU issue unit (issueint) in the Tomasulo-style out-of-order core.
- Accepts dispatched integer ops whose source operands may still be pending, and snoops the common data bus (CDB) to wake them up.
- Each cycle, selects the oldest entry with both operands ready and issues it to the ALU, provided the CDB arbiter has granted a result slot.
- Issue outputs are registered and drive the issueint inputs directly.

Parameters:
- DEPTH, 4: number of queue entries (2..8).
- TAG_W, 6: physical-register/ROB tag width.
- DATA_W, 32: operand width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  mispredict flush; kills all entries and any pending issue
- dispatch_valid  in  1  dispatch request this cycle
- dispatch_opcode  in  6  opcode/funct, encoded per globals.vh
- dispatch_rsdata  in  DATA_W  rs value (meaningful when rsvalid=1)
- dispatch_rsvalid  in  1  rs value present
- dispatch_rstag  in  TAG_W  rs producer tag (used when rsvalid=0)
- dispatch_rtdata  in  DATA_W  rt value
- dispatch_rtvalid  in  1  rt value present
- dispatch_rttag  in  TAG_W  rt producer tag
- dispatch_rdtag  in  TAG_W  destination tag
- issueque_full  out  1  queue full; dispatcher must not assert dispatch_valid while high
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- issueint_grant  in  1  CDB arbiter grants the ALU a result slot next cycle
- issueint_ready  out  1  issued op valid (one-cycle pulse per op)
- issueint_opcode  out  6  issued opcode
- issueint_rsdata  out  DATA_W  issued rs value
- issueint_rtdata  out  DATA_W  issued rt value
- issueint_rdtag  out  TAG_W  issued destination tag

Behaviour:
- Reset: all entry valid bits cleared, count=0. issueque_full=0. issueint_ready=0 and all issueint_* data/tag outputs =0.
- Storage is a collapsing queue. Entry 0 is the oldest. Each entry holds valid, opcode, rsdata/rsvalid/rstag, rtdata/rtvalid/rttag and rdtag.
- issueque_full is (count==DEPTH), taken from the registered count only. There is no same-cycle bypass of a freed slot.
- Dispatch while full is ignored. No entry is written and count is unchanged.
- Wakeup: for every valid entry whose operand is not valid, if cdb_valid and cdb_tag equals the operand tag, capture cdb_data and set the operand valid at the clock edge. rs and rt are checked independently, so both may wake on the same broadcast.
- Dispatch bypass: if a dispatched operand has valid=0 and its tag matches the CDB in the same cycle, it is stored as valid with cdb_data.
- Select:
  - Eligible = entry valid with rsvalid and rtvalid both already set at the start of the cycle. Wakeup and select never happen in the same cycle.
  - The lowest-index eligible entry wins.
- Issue: if a winner exists and issueint_grant=1, then at the edge:
  - the output register loads the winner's opcode, rsdata, rtdata and rdtag;
  - issueint_ready is set to 1;
  - the winner is removed, and entries above it shift down by one with wakeups applied to the shifted copies.
- If there is no winner or issueint_grant=0: issueint_ready=0 next cycle, and the data outputs hold their last values.
- Simultaneous issue and dispatch: the new entry is written at index count-1 after the shift, and count is unchanged.
- Minimum latency: dispatch with both operands valid at edge k; the entry is eligible in cycle k+1; issueint_ready=1 in cycle k+2. An operand woken by the CDB at edge j allows issueint_ready no earlier than cycle j+2.
- Flush has priority over everything. At the edge: all entries invalid, count=0, issueint_ready=0. Same-cycle dispatch, wakeup and issue are discarded.
- Reset mid-operation has the same effect as flush, plus it zeroes the output data registers.
- Tags are compared only on entries with the operand invalid. Stale tags in valid operands are don't-care.

Decomposition:
- globals.vh holds the opcode/funct constants already used by issueint, plus new ISSUEQ_DEPTH and TAG_W defines.
- One sub-module: issueque_select, a parameterised DEPTH-wide lowest-index priority encoder. Inputs are the eligible vector; outputs are a one-hot grant and the encoded index plus a found flag.

Test Plan:
1. Dispatch ADD with rs=5, rt=7, both valid, rdtag=3, grant=1 → two cycles later issueint_ready=1 for one cycle with rsdata=5, rtdata=7, rdtag=3.
2. Dispatch SUB with rs pending tag=9 and rt=2 valid; after 3 cycles, CDB tag=9 data=20 → no issue before CDB; issueint_ready two cycles after the CDB edge with rsdata=20.
3. Fill 4 entries, all pending → issueque_full=1. A fifth dispatch is dropped (count stays 4). A CDB wakeup of entry 2 only → entry 2 issues, full drops, entries 0, 1 and 3 remain in order.
4. Entries 0 and 1 both ready, grant held 0 for 3 cycles → no issue. Grant=1 → entry 0 issues first, then entry 1 on the next cycle.
5. Dispatch with rstag=12 invalid while CDB tag=12 data=0xABCD in the same cycle → operand captured; issues two cycles later with rsdata=0xABCD.
6. Three entries queued and one issue pending, then assert flush together with a dispatch → next cycle count=0, issueint_ready=0, issueque_full=0, and nothing issues afterwards.
